insn_sequencer: RTL



---
 rtl/insn_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/insn_sequencer.sv
// Instruction sequencer: fetches ROM words, drives config writes, dispatches engines, runs hardware loops.
// Latency: a word decoded in cycle N updates the registered strobes and the next iaddr at the end of cycle N.
// Backpressure: RUN to a busy channel, WAIT and EOC hold iaddr and issue nothing until the busy flags allow.
module insn_sequencer #(
    parameter int IW  = 32,
    parameter int AW  = 13,
    parameter int NCH = 4,
    parameter int CIW = 5,
    parameter int LD  = 4,
    parameter int CW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [AW-1:0]         iaddr,
    input  logic [IW-1:0]         idata,
    output logic                  cfg_we,
    output logic [CIW-1:0]        cfg_idx,
    output logic [IW-CIW-6:0]     cfg_data,
    output logic [NCH-1:0]        ch_start,
    input  logic [NCH-1:0]        ch_done,
    output logic [NCH-1:0]        ch_busy,
    output logic                  running,
    output logic                  halted,
    output logic                  err
);
    localparam int PW  = IW - 5;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SPW = $clog2(LD + 1);
    localparam int LIW = (LD > 1) ? $clog2(LD) : 1;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_CFG  = 5'd1;
    localparam logic [4:0] OP_RUN  = 5'd2;
    localparam logic [4:0] OP_WAIT = 5'd3;
    localparam logic [4:0] OP_LOOP = 5'd4;
    localparam logic [4:0] OP_ENDL = 5'd5;
    localparam logic [4:0] OP_EOC  = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT, S_ERR} state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         iaddr_nxt;
    logic                  cfg_we_nxt;
    logic [CIW-1:0]        cfg_idx_nxt;
    logic [IW-CIW-6:0]     cfg_data_nxt;
    logic [NCH-1:0]        ch_start_nxt;
    logic [NCH-1:0]        ch_busy_nxt;

    // Loop stack: return address and remaining count per nesting level; sp counts valid entries.
    logic [AW-1:0]         stk_addr [LD];
    logic [CW-1:0]         stk_cnt  [LD];
    logic [SPW-1:0]        sp;
    logic                  stk_clr, stk_push, stk_pop, stk_dec;

    logic [4:0]            opcode;
    logic [PW-1:0]         pay;
    logic [CHW-1:0]        run_ch;
    logic [NCH-1:0]        wait_mask;
    logic [CW-1:0]         loop_n;
    logic [LIW-1:0]        push_idx, top_idx;

    assign opcode    = idata[IW-1:IW-5];
    assign pay       = idata[PW-1:0];
    assign run_ch    = pay[CHW-1:0];
    // An all-zero mask is shorthand for "every channel".
    assign wait_mask = (pay[NCH-1:0] == '0) ? '1 : pay[NCH-1:0];
    // A zero trip count still executes the body once.
    assign loop_n    = (pay[CW-1:0] == '0) ? CW'(1) : pay[CW-1:0];
    assign push_idx  = LIW'(sp);
    assign top_idx   = LIW'(sp - 1'b1);

    assign running = (state == S_EXEC);
    assign halted  = (state == S_HALT);
    assign err     = (state == S_ERR);

    // Next-state, next-output and stack control decode; everything defaults to hold/no-op.
    always_comb begin
        state_nxt    = state;
        iaddr_nxt    = iaddr;
        cfg_we_nxt   = 1'b0;
        cfg_idx_nxt  = cfg_idx;
        cfg_data_nxt = cfg_data;
        ch_start_nxt = '0;
        stk_clr      = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_dec      = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_EXEC;
                    iaddr_nxt = '0;
                    stk_clr   = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_NOP: iaddr_nxt = iaddr + 1'b1;
                    OP_CFG: begin
                        cfg_we_nxt   = 1'b1;
                        cfg_idx_nxt  = pay[PW-1:PW-CIW];
                        cfg_data_nxt = pay[PW-CIW-1:0];
                        iaddr_nxt    = iaddr + 1'b1;
                    end
                    OP_RUN: begin
                        // With NCH a power of two this range check cannot fire.
                        if (32'(run_ch) >= 32'(NCH)) begin
                            state_nxt = S_ERR;
                        end else if (!ch_busy[run_ch]) begin
                            ch_start_nxt[run_ch] = 1'b1;
                            iaddr_nxt            = iaddr + 1'b1;
                        end
                    end
                    OP_WAIT: begin
                        if ((ch_busy & wait_mask) == '0) iaddr_nxt = iaddr + 1'b1;
                    end
                    OP_LOOP: begin
                        if (sp == SPW'(LD)) begin
                            state_nxt = S_ERR;
                        end else begin
                            stk_push  = 1'b1;
                            iaddr_nxt = iaddr + 1'b1;
                        end
                    end
                    OP_ENDL: begin
                        if (sp == '0) begin
                            state_nxt = S_ERR;
                        end else if (stk_cnt[top_idx] > CW'(1)) begin
                            stk_dec   = 1'b1;
                            iaddr_nxt = stk_addr[top_idx];
                        end else begin
                            stk_pop   = 1'b1;
                            iaddr_nxt = iaddr + 1'b1;
                        end
                    end
                    OP_EOC: begin
                        if (ch_busy == '0) state_nxt = S_HALT;
                    end
                    default: state_nxt = S_ERR;
                endcase
            end
            default: ;
        endcase
        // Done clears first so a start issued this cycle always wins on its own bit.
        ch_busy_nxt = (ch_busy & ~ch_done) | ch_start_nxt;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            iaddr    <= '0;
            cfg_we   <= 1'b0;
            cfg_idx  <= '0;
            cfg_data <= '0;
            ch_start <= '0;
            ch_busy  <= '0;
        end else begin
            state    <= state_nxt;
            iaddr    <= iaddr_nxt;
            cfg_we   <= cfg_we_nxt;
            cfg_idx  <= cfg_idx_nxt;
            cfg_data <= cfg_data_nxt;
            ch_start <= ch_start_nxt;
            ch_busy  <= ch_busy_nxt;
        end
    end

    // Loop stack update: push on LOOP, decrement or pop on ENDL, clear on (re)start.
    always_ff @(posedge clk) begin
        if (rst || stk_clr) begin
            sp <= '0;
        end else if (stk_push) begin
            stk_addr[push_idx] <= iaddr + 1'b1;
            stk_cnt[push_idx]  <= loop_n;
            sp                 <= sp + 1'b1;
        end else if (stk_pop) begin
            sp <= sp - 1'b1;
        end else if (stk_dec) begin
            stk_cnt[top_idx] <= stk_cnt[top_idx] - 1'b1;
        end
    end
endmodule
